idiv_seq: RTL and testbench
===========================

Name: idiv_seq

Overview:
Iterative radix-2 restoring integer divider implementing RV M-extension DIV/DIVU/REM/REMU. It is the counterpart to the single-cycle multiply path in the muldiv unit. Operands are captured from the Execute-stage forwarded sources. It takes multiple cycles and raises a busy flag so the hazard unit can stall the pipeline. The quotient and remainder are held until the Memory/Writeback stage consumes them.

Parameters:
XLEN, 64, datapath width in bits (32 or 64).
CW, $clog2(XLEN)+1, iteration counter width.

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset
StartE  input  1  request a divide; accepted only in IDLE or DONE
FlushE  input  1  abort any in-flight operation
AckM  input  1  result consumed; DONE returns to IDLE
Funct3E  input  3  100=DIV, 101=DIVU, 110=REM, 111=REMU
ForwardedSrcAE  input  XLEN  dividend
ForwardedSrcBE  input  XLEN  divisor
W64E  input  1  word op (DIVW etc.); only used when IDIV_WOPS_EN is defined
BusyE  output  1  high in BUSY and FIX
DoneM  output  1  high in DONE
QuotM  output  XLEN  final quotient
RemM  output  XLEN  final remainder

Behaviour:
- Reset (reset==0, async):
  - state=IDLE.
  - BusyE=0, DoneM=0, QuotM=0, RemM=0.
  - Internal registers cleared.
- States: IDLE, BUSY, FIX, DONE.
- IDLE / DONE with StartE && !FlushE:
  - Latch operands, signed flag (~Funct3E[0]) and rem flag (Funct3E[1]).
  - Signed ops: latch |A| and |B|, and record the dividend and divisor signs.
  - Clear the partial remainder and load count=XLEN.
  - Special case, divisor==0: Q=all-ones, R=dividend; go directly to DONE.
  - Special case, signed and dividend==most-negative and divisor==all-ones: Q=dividend, R=0; go directly to DONE.
  - Otherwise go to BUSY.
- BUSY, one restoring step per cycle:
  - P' = {P[XLEN-1:0], A[XLEN-1]}, A shifted left by 1.
  - If P' >= B: P = P'-B and A[0]=1. Otherwise P = P' and A[0]=0.
  - count decrements each step; go to FIX when count reaches 1.
- FIX:
  - Quotient negated if the dividend sign differs from the divisor sign (signed op only).
  - Remainder negated if the dividend is negative (signed op only).
  - Write QuotM and RemM; go to DONE.
- Latency from the accepting edge:
  - Normal op: DoneM rises XLEN+1 edges later.
  - Special case: DoneM rises 1 edge later.
- DONE:
  - Outputs held stable until AckM. AckM goes to IDLE.
  - AckM && StartE in the same cycle starts the new op; the old result remains on QuotM/RemM until the new FIX or special-case write.
- FlushE in any state: next state IDLE, BusyE=0, DoneM=0. QuotM/RemM are left unchanged.
- FlushE takes priority over StartE and AckM.
- StartE while BUSY or FIX is ignored (no restart). The hazard unit must not assert it.
- Partial remainder P is XLEN+1 bits wide for the compare and subtract.

Optional Feature:
Macro IDIV_WOPS_EN.
- Defined:
  - When XLEN==64 and W64E=1, the operands are the low 32 bits, sign- or zero-extended per Funct3E.
  - count loads 32, so latency is 33.
  - QuotM/RemM are the 32-bit results sign-extended to 64 bits.
  - The special cases use 32-bit constants.
- Undefined: W64E is ignored and all ops run XLEN-wide.

Decomposition:
- Package idiv_pkg:
  - state enum typedef (IDLE, BUSY, FIX, DONE).
  - Funct3 localparams DIV/DIVU/REM/REMU.
- Sub-module idiv_step: combinational single restoring iteration.
  - Inputs: P, A, B.
  - Outputs: next P, next A.

Test Plan:
- XLEN=64, DIVU 100/7: BusyE high 65 cycles, DoneM at edge 65 after start; QuotM=14, RemM=2; AckM gives DoneM=0.
- DIV -7/2 then REM -7/2: QuotM=0xFFFF_FFFF_FFFF_FFFD (-3), RemM=0xFFFF_FFFF_FFFF_FFFF (-1).
- DIVU 0x1234/0: DoneM 1 cycle after start; QuotM=all-ones, RemM=0x1234.
- DIV 0x8000_0000_0000_0000 / 0xFFFF_FFFF_FFFF_FFFF: DoneM after 1 cycle; QuotM=0x8000_0000_0000_0000, RemM=0.
- Flush mid-op: FlushE at BUSY cycle 20 gives IDLE next edge with Busy/Done 0. Restart with 50/5 gives Q=10, R=0. Separately, reset low at cycle 30 clears all outputs immediately.
- IDIV_WOPS_EN, DIVW 0xFFFF_FFFF_FFFF_FFF9 (-7) / 2: latency 33; QuotM=0xFFFF_FFFF_FFFF_FFFD, RemM=all-ones.

Source files
------------

// File: rtl/idiv_pkg.sv
// Shared definitions for the iterative integer divider: FSM state encoding
// and the RV M-extension funct3 codes it serves.
package idiv_pkg;

   typedef logic [1:0] state_t;

   localparam state_t S_IDLE = 2'd0;
   localparam state_t S_BUSY = 2'd1;
   localparam state_t S_FIX  = 2'd2;
   localparam state_t S_DONE = 2'd3;

   localparam logic [2:0] F3_DIV  = 3'b100;
   localparam logic [2:0] F3_DIVU = 3'b101;
   localparam logic [2:0] F3_REM  = 3'b110;
   localparam logic [2:0] F3_REMU = 3'b111;

endpackage

// File: rtl/idiv_step.sv
// One radix-2 restoring division step: shift the next dividend bit into the
// partial remainder, subtract the divisor when it fits, record the quotient bit.
module idiv_step
   import idiv_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic [XLEN:0]   p,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic [XLEN:0]   p_nxt,
   output logic [XLEN-1:0] a_nxt
);

   logic [XLEN+1:0] p_sh;
   logic [XLEN:0]   diff;
   logic            ge;

   always_comb begin
      p_sh  = {p, a[XLEN-1]};
      ge    = (p_sh >= {2'b00, b});
      diff  = p_sh[XLEN:0] - {1'b0, b};
      p_nxt = ge ? diff : p_sh[XLEN:0];
      a_nxt = {a[XLEN-2:0], ge};
   end

endmodule

// File: rtl/idiv_seq.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU with busy/done handshake.
// Optional 32-bit word ops (DIVW etc.) on XLEN=64 are enabled by IDIV_WOPS_EN.
module idiv_seq
   import idiv_pkg::*;
#(
   parameter int XLEN = 64,
   parameter int CW   = $clog2(XLEN) + 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            StartE,
   input  logic            FlushE,
   input  logic            AckM,
   input  logic [2:0]      Funct3E,
   input  logic [XLEN-1:0] ForwardedSrcAE,
   input  logic [XLEN-1:0] ForwardedSrcBE,
   input  logic            W64E,
   output logic            BusyE,
   output logic            DoneM,
   output logic [XLEN-1:0] QuotM,
   output logic [XLEN-1:0] RemM
);

   state_t          state;
   logic [XLEN-1:0] a_r, b_r;
   logic [XLEN:0]   p_r;
   logic [CW-1:0]   cnt;
   logic            sgn_r, sa_r, sb_r, wop_r;
   logic [XLEN:0]   p_nxt;
   logic [XLEN-1:0] a_nxt;

   function automatic logic [XLEN-1:0] sext32(input logic [31:0] x);
      logic signed [31:0] t;
      t = x;
      return XLEN'(t);
   endfunction

   function automatic logic [XLEN-1:0] neg_if(input logic n, input logic [XLEN-1:0] x);
      return n ? -x : x;
   endfunction

   logic       wop;
   logic [1:0] unused_f3;
   assign unused_f3 = Funct3E[2:1];

`ifdef IDIV_WOPS_EN
   assign wop = (XLEN == 64) && W64E;
`else
   logic unused_w64;
   assign wop        = 1'b0;
   assign unused_w64 = W64E;
`endif

   logic            sgn, sa, sb, div0, ovf;
   logic [XLEN-1:0] ax, bx, amag, bmag, a_load, minv, q_sp, r_sp;

   always_comb begin
      sgn  = ~Funct3E[0];
      ax   = ForwardedSrcAE;
      bx   = ForwardedSrcBE;
      minv = {1'b1, {(XLEN-1){1'b0}}};
      if (wop) begin
         ax   = sgn ? sext32(ForwardedSrcAE[31:0]) : XLEN'(ForwardedSrcAE[31:0]);
         bx   = sgn ? sext32(ForwardedSrcBE[31:0]) : XLEN'(ForwardedSrcBE[31:0]);
         minv = sext32(32'h8000_0000);
      end
      sa   = sgn & ax[XLEN-1];
      sb   = sgn & bx[XLEN-1];
      amag = neg_if(sa, ax);
      bmag = neg_if(sb, bx);
      // Word ops park the 32-bit magnitude in the top half so 32 shifts consume it.
      a_load = wop ? (amag << (XLEN-32)) : amag;
      div0   = (bx == '0);
      ovf    = sgn && (ax == minv) && (bx == '1);
      q_sp   = div0 ? '1 : ax;
      r_sp   = div0 ? ax : '0;
      if (wop) begin
         q_sp = sext32(q_sp[31:0]);
         r_sp = sext32(r_sp[31:0]);
      end
   end

   logic [XLEN-1:0] q_fix, r_fix;

   always_comb begin
      q_fix = neg_if(sgn_r && (sa_r != sb_r), a_r);
      r_fix = neg_if(sgn_r && sa_r, p_r[XLEN-1:0]);
      if (wop_r) begin
         q_fix = sext32(q_fix[31:0]);
         r_fix = sext32(r_fix[31:0]);
      end
   end

   idiv_step #(.XLEN(XLEN)) u_step (
      .p     (p_r),
      .a     (a_r),
      .b     (b_r),
      .p_nxt (p_nxt),
      .a_nxt (a_nxt)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
         a_r   <= '0;
         b_r   <= '0;
         p_r   <= '0;
         cnt   <= '0;
         sgn_r <= 1'b0;
         sa_r  <= 1'b0;
         sb_r  <= 1'b0;
         wop_r <= 1'b0;
         QuotM <= '0;
         RemM  <= '0;
      end else if (FlushE) begin
         state <= S_IDLE;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (StartE) begin
                  a_r   <= a_load;
                  b_r   <= bmag;
                  p_r   <= '0;
                  cnt   <= wop ? CW'(32) : CW'(XLEN);
                  sgn_r <= sgn;
                  sa_r  <= sa;
                  sb_r  <= sb;
                  wop_r <= wop;
                  if (div0 || ovf) begin
                     QuotM <= q_sp;
                     RemM  <= r_sp;
                     state <= S_DONE;
                  end else begin
                     state <= S_BUSY;
                  end
               end else if (AckM) begin
                  state <= S_IDLE;
               end
            end
            S_BUSY: begin
               p_r <= p_nxt;
               a_r <= a_nxt;
               cnt <= cnt - CW'(1);
               if (cnt == CW'(1)) state <= S_FIX;
            end
            S_FIX: begin
               QuotM <= q_fix;
               RemM  <= r_fix;
               state <= S_DONE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign BusyE = (state == S_BUSY) || (state == S_FIX);
   assign DoneM = (state == S_DONE);

endmodule

// File: tb/tb_idiv_seq.sv
// Directed bench for idiv_seq (XLEN=64): vector table plus handshake,
// flush and reset sequences; word-op vectors when IDIV_WOPS_EN is defined.
module tb_idiv_seq;
   import idiv_pkg::*;

   localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] MIN  = 64'h8000_0000_0000_0000;

   logic        clk, reset, StartE, FlushE, AckM, W64E;
   logic [2:0]  Funct3E;
   logic [63:0] SrcA, SrcB, QuotM, RemM;
   logic        BusyE, DoneM;

   int ncmp = 0;
   int nerr = 0;

   idiv_seq #(.XLEN(64)) dut (
      .clk            (clk),
      .reset          (reset),
      .StartE         (StartE),
      .FlushE         (FlushE),
      .AckM           (AckM),
      .Funct3E        (Funct3E),
      .ForwardedSrcAE (SrcA),
      .ForwardedSrcBE (SrcB),
      .W64E           (W64E),
      .BusyE          (BusyE),
      .DoneM          (DoneM),
      .QuotM          (QuotM),
      .RemM           (RemM)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // lat counts rising edges from the accepting edge (=1) until DoneM is seen.
   typedef struct {
      logic [2:0]  f3;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] q;
      logic [63:0] r;
      int          lat;
      int          busy;
   } vec_t;

   localparam int NV = 17;
   vec_t vt [NV];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      ncmp++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h, want %0h", nm, act, exp);
      end
   endtask

   task automatic start_op(input logic [2:0] f3, input logic [63:0] a,
                           input logic [63:0] b, input logic w);
      @(negedge clk);
      Funct3E = f3;
      SrcA    = a;
      SrcB    = b;
      W64E    = w;
      StartE  = 1'b1;
      @(negedge clk);
      StartE  = 1'b0;
   endtask

   task automatic wait_done(output int lat, output int busy);
      lat  = 1;
      busy = 0;
      while (!DoneM && lat < 300) begin
         if (BusyE) busy++;
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic ack_chk(input string nm);
      AckM = 1'b1;
      @(negedge clk);
      AckM = 1'b0;
      chk(nm, {63'd0, DoneM}, 64'd0);
   endtask

   int lat, busy;

   initial begin
      vt[0]  = '{F3_DIVU, 64'd100, 64'd7, 64'd14, 64'd2, 66, 65};
      vt[1]  = '{F3_DIV,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
                 64'hFFFF_FFFF_FFFF_FFFD, ONES, 66, 65};
      vt[2]  = '{F3_REM,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
                 64'hFFFF_FFFF_FFFF_FFFD, ONES, 66, 65};
      vt[3]  = '{F3_DIVU, 64'h1234, 64'd0, ONES, 64'h1234, 1, 0};
      vt[4]  = '{F3_DIV,  MIN, ONES, MIN, 64'd0, 1, 0};
      vt[5]  = '{F3_DIVU, 64'd50, 64'd5, 64'd10, 64'd0, 66, 65};
      vt[6]  = '{F3_DIV,  64'd7, 64'hFFFF_FFFF_FFFF_FFFE,
                 64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 66, 65};
      vt[7]  = '{F3_REMU, ONES, 64'd1, ONES, 64'd0, 66, 65};
      vt[8]  = '{F3_DIV,  64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FFF9,
                 64'd14, 64'hFFFF_FFFF_FFFF_FFFE, 66, 65};
      vt[9]  = '{F3_DIVU, ONES, 64'h10, 64'h0FFF_FFFF_FFFF_FFFF, 64'hF, 66, 65};
      vt[10] = '{F3_DIV,  64'd5, 64'd0, ONES, 64'd5, 1, 0};
      vt[11] = '{F3_REM,  MIN, ONES, MIN, 64'd0, 1, 0};
      vt[12] = '{F3_DIVU, MIN, 64'd3, 64'h2AAA_AAAA_AAAA_AAAA, 64'd2, 66, 65};
      vt[13] = '{F3_DIVU, MIN, ONES, 64'd0, MIN, 66, 65};
      vt[14] = '{F3_REMU, 64'd0, 64'd0, ONES, 64'd0, 1, 0};
      vt[15] = '{F3_DIVU, ONES, 64'h8000_0000_0000_0001,
                 64'd1, 64'h7FFF_FFFF_FFFF_FFFE, 66, 65};
      vt[16] = '{F3_DIV,  MIN, 64'd2, 64'hC000_0000_0000_0000, 64'd0, 66, 65};

      reset = 1'b0; StartE = 1'b0; FlushE = 1'b0; AckM = 1'b0; W64E = 1'b0;
      Funct3E = F3_DIVU; SrcA = '0; SrcB = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy", {63'd0, BusyE}, 64'd0);
      chk("rst_done", {63'd0, DoneM}, 64'd0);
      chk("rst_q", QuotM, 64'd0);
      chk("rst_r", RemM, 64'd0);
      reset = 1'b1;
      @(negedge clk);
      chk("idle_busy", {63'd0, BusyE}, 64'd0);

      for (int i = 0; i < NV; i++) begin
         start_op(vt[i].f3, vt[i].a, vt[i].b, 1'b0);
         wait_done(lat, busy);
         chk($sformatf("v%0d_lat", i), 64'(lat), 64'(vt[i].lat));
         chk($sformatf("v%0d_busy", i), 64'(busy), 64'(vt[i].busy));
         chk($sformatf("v%0d_q", i), QuotM, vt[i].q);
         chk($sformatf("v%0d_r", i), RemM, vt[i].r);
         ack_chk($sformatf("v%0d_ack", i));
      end

      // StartE while busy must not restart the operation.
      start_op(F3_DIVU, 64'd100, 64'd7, 1'b0);
      repeat (9) @(negedge clk);
      SrcA = 64'd9; SrcB = 64'd3; StartE = 1'b1;
      @(negedge clk);
      StartE = 1'b0;
      wait_done(lat, busy);
      chk("ign_q", QuotM, 64'd14);
      chk("ign_r", RemM, 64'd2);
      ack_chk("ign_ack");

      // Flush mid-operation, with a simultaneous StartE that must lose.
      start_op(F3_DIVU, 64'd100, 64'd7, 1'b0);
      repeat (19) @(negedge clk);
      SrcA = 64'd9; SrcB = 64'd3;
      FlushE = 1'b1; StartE = 1'b1;
      @(negedge clk);
      FlushE = 1'b0; StartE = 1'b0;
      chk("fl_busy", {63'd0, BusyE}, 64'd0);
      chk("fl_done", {63'd0, DoneM}, 64'd0);
      chk("fl_q_held", QuotM, 64'd14);
      chk("fl_r_held", RemM, 64'd2);
      @(negedge clk);
      chk("fl_stay_idle", {63'd0, BusyE}, 64'd0);
      start_op(F3_DIVU, 64'd50, 64'd5, 1'b0);
      wait_done(lat, busy);
      chk("fl_re_lat", 64'(lat), 64'd66);
      chk("fl_re_q", QuotM, 64'd10);
      chk("fl_re_r", RemM, 64'd0);

      // AckM and StartE together from DONE: new op starts, old result held.
      AckM = 1'b1; StartE = 1'b1;
      Funct3E = F3_DIVU; SrcA = 64'd100; SrcB = 64'd7; W64E = 1'b0;
      @(negedge clk);
      AckM = 1'b0; StartE = 1'b0;
      chk("as_busy", {63'd0, BusyE}, 64'd1);
      chk("as_done", {63'd0, DoneM}, 64'd0);
      chk("as_q_old", QuotM, 64'd10);
      wait_done(lat, busy);
      chk("as_lat", 64'(lat), 64'd66);
      chk("as_q", QuotM, 64'd14);
      chk("as_r", RemM, 64'd2);
      ack_chk("as_ack");

      // Asynchronous reset mid-operation clears outputs without a clock edge.
      start_op(F3_DIV, 64'd50, 64'd5, 1'b0);
      repeat (29) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      chk("ar_busy", {63'd0, BusyE}, 64'd0);
      chk("ar_done", {63'd0, DoneM}, 64'd0);
      chk("ar_q", QuotM, 64'd0);
      chk("ar_r", RemM, 64'd0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("ar_idle", {63'd0, BusyE}, 64'd0);

`ifdef IDIV_WOPS_EN
      start_op(F3_DIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1);
      wait_done(lat, busy);
      chk("w_lat", 64'(lat), 64'd34);
      chk("w_busy", 64'(busy), 64'd33);
      chk("w_q", QuotM, 64'hFFFF_FFFF_FFFF_FFFD);
      chk("w_r", RemM, ONES);
      ack_chk("w_ack");
      start_op(F3_DIVU, 64'hABCD_0000_0000_0064, 64'h5555_0000_0000_0007, 1'b1);
      wait_done(lat, busy);
      chk("wu_q", QuotM, 64'd14);
      chk("wu_r", RemM, 64'd2);
      ack_chk("wu_ack");
      start_op(F3_DIV, 64'h1234_5678_8000_0000, 64'h0000_0001_FFFF_FFFF, 1'b1);
      wait_done(lat, busy);
      chk("wo_lat", 64'(lat), 64'd1);
      chk("wo_q", QuotM, 64'hFFFF_FFFF_8000_0000);
      chk("wo_r", RemM, 64'd0);
      ack_chk("wo_ack");
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
